write_buffer: RTL and testbench
===============================

# write_buffer

Posted-write buffer between the write-through data cache and data memory. It absorbs the cache's store traffic (address, data, byte-op) in a small FIFO and drains it to memory through a req/ack handshake. Cache-miss loads go out on the same port: they are forwarded from the buffer when possible and otherwise issued as memory reads. It stalls the pipeline when the buffer is full or a load must wait for memory.

## Interface
- WIDTH, 32: data/address width.
- DEPTH, 4: FIFO entries, power of two, ≥2.

- clk_i  in  1  clock, rising-edge.
- rst_ni  in  1  asynchronous active-low reset.
- wr_en_i  in  1  cache store request (cache mem_write_enable_o).
- rd_en_i  in  1  cache load request.
- byte_op_i  in  1  store is a byte store (cache mem_byte_op_o).
- addr_i  in  WIDTH  byte address (cache mem_address_o).
- wdata_i  in  WIDTH  store data; byte stores use [7:0].
- rdata_o  out  WIDTH  full word returned to cache mem_incoming_data_i. The cache does the byte selection.
- stall_o  out  1  pipeline hold.
- mem_req_o, mem_we_o, mem_byte_op_o  out  1  memory request, write enable, byte op.
- mem_addr_o, mem_wdata_o  out  WIDTH  memory address/data.
- mem_ack_i  in  1  memory completes the current request at this rising edge.
- mem_rdata_i  in  WIDTH  read data, valid in the ack cycle.

## Operation
- **Entry contents:** {addr, data, byte_op}. Circular FIFO with head/tail pointers (log2 DEPTH bits, wrap-around) plus a count of 0..DEPTH.
- **Enqueue:** at the rising edge where wr_en_i=1 and count<DEPTH.
- **Store and load together:** if wr_en_i and rd_en_i are both high, the store wins and rd_en_i is ignored.
- **Forwarding:**
  - On rd_en_i, compare addr_i[31:2] against every valid entry.
  - If the youngest match is a word store, its data goes to rdata_o combinationally, with stall_o=0 and no memory access.
  - If the youngest match is a byte store, this is a conflict: the load stalls and the buffer drains until no match remains.
- **FSM states:**
  - IDLE: mem_req_o=0.
  - DRAIN: mem_req_o=1, mem_we_o=1; head entry on mem_addr_o, mem_wdata_o and mem_byte_op_o.
  - READ: mem_req_o=1, mem_we_o=0, mem_addr_o=addr_i, mem_byte_op_o=0.
- **Transitions from IDLE:**
  - rd_en_i with no match → READ.
  - Otherwise, count>0 → DRAIN.
  - Loads have priority over draining.
- **Transitions from DRAIN (on mem_ack_i):**
  - Pop the head.
  - Then apply the IDLE priority rule to the post-pop state, going directly to READ, DRAIN or IDLE.
  - Without ack, hold the state.
- **Transitions from READ:** on mem_ack_i, go to IDLE.
- **Request stability:** mem_* outputs stay constant while mem_req_o=1 and ack is low. A request is never withdrawn before ack.
- **stall_o** is combinational; it is high when either:
  - wr_en_i and count==DEPTH (no credit for a same-cycle pop), or
  - rd_en_i and not (forward hit) and not (state==READ and mem_ack_i).
- **rdata_o:**
  - Forwarded data on a forward hit.
  - mem_rdata_i when state==READ and mem_ack_i.
  - 0 otherwise.
- **Simultaneous enqueue and pop:** count is unchanged and both pointers advance.

## Timing
- **Reset (async):** head=tail=count=0, state=IDLE. Outputs: mem_req_o=0, mem_we_o=0, stall_o=0, rdata_o=0; mem_addr_o/mem_wdata_o/mem_byte_op_o=0 in IDLE. Any in-flight request is dropped immediately and buffered stores are discarded.
- **Store to memory:** a store enqueued at edge E0 gives mem_req_o=1 after edge E1. The earliest pop is at E2 (ack held high).
- **Back-to-back drain:** with ack tied high, one entry retires per cycle.
- **Load miss:**
  - Issued in IDLE at cycle C: READ is entered at the next edge.
  - stall_o is high from C until the ack cycle.
  - In the ack cycle, stall_o=0 and rdata_o is valid.
  - Minimum load miss = 2 cycles.
- **Load during DRAIN:** it waits for the current write ack (stall_o=1), then READ.
- **Forward hit:** 0 extra cycles.

## Test plan
- **Reset mid-transaction:** reset asserted during READ with ack low → mem_req_o drops to 0 asynchronously. After release, count=0 and state=IDLE.
- **Single store drain:** store word 0xDEADBEEF at 0x100, ack tied 1 → exactly one write beat, at the E1→E2 cycle, with mem_addr_o=0x100, mem_wdata_o=0xDEADBEEF, mem_byte_op_o=0, mem_we_o=1. Then IDLE.
- **Full buffer:** 5 stores to 0x0,0x4,…,0x10 with ack=0 → stall_o=1 on the 5th. Release ack=1 → memory sees writes in order 0x0..0xC, then 0x10. Pointers wrap correctly.
- **Forwarding:** word stores 0x11111111 and then 0x22222222 to 0x200, ack=0, then load 0x200 → rdata_o=0x22222222 in the same cycle, stall_o=0, no READ.
- **Byte conflict:** byte store 0xAB to 0x203, then load 0x200 → stall until that entry drains. Then READ issued; rdata_o=mem_rdata_i in the ack cycle.
- **Load-miss priority:** 2 stores pending, load 0x300 arrives in IDLE → READ precedes both drains. With a 3-cycle ack delay, stall_o is high 4 cycles and low in the ack cycle.

Source files
------------

// File: rtl/write_buffer.sv
// Posted-write FIFO between the write-through D-cache and data memory.
// Ports: cache side (wr/rd/addr/wdata/rdata/stall), memory req/ack side.
module write_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic             rd_en_i,
  input  logic             byte_op_i,
  input  logic [WIDTH-1:0] addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             stall_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             mem_byte_op_o,
  output logic [WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0] mem_wdata_o,
  input  logic             mem_ack_i,
  input  logic [WIDTH-1:0] mem_rdata_i
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    READ
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] addr_q [DEPTH];
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] byte_q;

  logic [AW-1:0] head_q, tail_q;
  logic [AW:0]   count_q;

  logic             hit_any, hit_byte, post_any;
  logic [WIDTH-1:0] hit_data;
  logic [AW-1:0]    idx;

  logic rd_eff, fwd_hit, full, enq, pop, read_done;

  // Youngest match wins: later slots overwrite earlier ones.
  // post_any ignores the head so DRAIN can decide after its pop.
  always_comb begin
    hit_any  = 1'b0;
    hit_byte = 1'b0;
    post_any = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + AW'(i);
      if (((AW+1)'(i) < count_q) &&
          (addr_q[idx][WIDTH-1:2] == addr_i[WIDTH-1:2])) begin
        hit_any  = 1'b1;
        hit_byte = byte_q[idx];
        hit_data = data_q[idx];
        if (i != 0) post_any = 1'b1;
      end
    end
  end

  assign rd_eff    = rd_en_i & ~wr_en_i;
  assign fwd_hit   = rd_eff & hit_any & ~hit_byte;
  assign full      = (count_q == (AW+1)'(DEPTH));
  assign enq       = wr_en_i & ~full;
  assign pop       = (state_q == DRAIN) & mem_ack_i;
  assign read_done = (state_q == READ) & mem_ack_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (enq) tail_q <= tail_q + AW'(1);
      if (pop) head_q <= head_q + AW'(1);
      unique case ({enq, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) begin
      addr_q[tail_q] <= addr_i;
      data_q[tail_q] <= wdata_i;
      byte_q[tail_q] <= byte_op_i;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (rd_eff && !hit_any)   state_d = READ;
        else if (count_q != '0)   state_d = DRAIN;
      end
      DRAIN: begin
        if (mem_ack_i) begin
          if (rd_eff && !post_any)             state_d = READ;
          else if (count_q > (AW+1)'(1) || enq) state_d = DRAIN;
          else                                  state_d = IDLE;
        end
      end
      READ: begin
        if (mem_ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    mem_byte_op_o = 1'b0;
    mem_addr_o    = '0;
    mem_wdata_o   = '0;
    unique case (state_q)
      DRAIN: begin
        mem_req_o     = 1'b1;
        mem_we_o      = 1'b1;
        mem_byte_op_o = byte_q[head_q];
        mem_addr_o    = addr_q[head_q];
        mem_wdata_o   = data_q[head_q];
      end
      READ: begin
        mem_req_o  = 1'b1;
        mem_addr_o = addr_i;
      end
      default: ;
    endcase
  end

  // A full buffer stalls even if the head pops this cycle.
  assign stall_o = (wr_en_i & full) |
                   (rd_eff & ~fwd_hit & ~read_done);

  assign rdata_o = fwd_hit   ? hit_data :
                   read_done ? mem_rdata_i : '0;

endmodule

// File: tb/tb_write_buffer.sv
// Directed bench for write_buffer.
// Steps drive after posedge and compare mid-cycle.
module tb_write_buffer;

  logic        clk, rst_n;
  logic        wr_en, rd_en, byte_op, ack;
  logic [31:0] addr, wdata, mrdata;
  logic [31:0] rdata, maddr, mwdata;
  logic        stall, req, we, mbyte;

  int checks = 0;
  int errors = 0;

  write_buffer #(.WIDTH(32), .DEPTH(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .wr_en_i(wr_en), .rd_en_i(rd_en),
    .byte_op_i(byte_op), .addr_i(addr),
    .wdata_i(wdata), .rdata_o(rdata),
    .stall_o(stall), .mem_req_o(req),
    .mem_we_o(we), .mem_byte_op_o(mbyte),
    .mem_addr_o(maddr), .mem_wdata_o(mwdata),
    .mem_ack_i(ack), .mem_rdata_i(mrdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 0; rd_en = 0; byte_op = 0;
    ack = 0; addr = '0; wdata = '0; mrdata = '0;
    #12;
    check("rst_req", 32'(req), 0);
    check("rst_we", 32'(we), 0);
    check("rst_stall", 32'(stall), 0);
    check("rst_rdata", rdata, 0);
    check("rst_addr", maddr, 0);
    step();
    rst_n = 1'b1;

    // single store drain, ack tied high
    ack = 1;
    wr_en = 1; addr = 32'h100; wdata = 32'hDEADBEEF;
    settle();
    check("st_stall", 32'(stall), 0);
    check("st_req0", 32'(req), 0);
    step(); wr_en = 0; settle();
    check("st_req_e1", 32'(req), 0);
    step(); settle();
    check("st_req", 32'(req), 1);
    check("st_we", 32'(we), 1);
    check("st_addr", maddr, 32'h100);
    check("st_data", mwdata, 32'hDEADBEEF);
    check("st_byte", 32'(mbyte), 0);
    step(); settle();
    check("st_idle", 32'(req), 0);
    ack = 0;

    // full buffer and wrap-around
    for (int k = 0; k < 4; k++) begin
      wr_en = 1; addr = 32'(4 * k); wdata = 32'hA0 + 32'(k);
      settle();
      check("fb_stall_lo", 32'(stall), 0);
      step();
    end
    addr = 32'h10; wdata = 32'hA4; settle();
    check("fb_stall5", 32'(stall), 1);
    check("fb_head", maddr, 32'h0);
    step();
    ack = 1; settle();
    check("fb_stall_pop", 32'(stall), 1);
    check("fb_w0", maddr, 32'h0);
    step(); settle();
    check("fb_stall_free", 32'(stall), 0);
    check("fb_w1", maddr, 32'h4);
    step(); wr_en = 0; settle();
    check("fb_w2", maddr, 32'h8);
    step(); settle();
    check("fb_w3", maddr, 32'hC);
    step(); settle();
    check("fb_w4", maddr, 32'h10);
    check("fb_d4", mwdata, 32'hA4);
    step(); settle();
    check("fb_idle", 32'(req), 0);
    ack = 0;

    // forwarding youngest word store
    wr_en = 1; addr = 32'h200; wdata = 32'h11111111;
    step();
    wdata = 32'h22222222;
    step();
    wr_en = 0; rd_en = 1; addr = 32'h200; settle();
    check("fw_rdata", rdata, 32'h22222222);
    check("fw_stall", 32'(stall), 0);
    check("fw_no_read", 32'(we), 1);
    step(); rd_en = 0; ack = 1;
    step(); step(); settle();
    check("fw_idle", 32'(req), 0);
    ack = 0;

    // byte conflict
    wr_en = 1; byte_op = 1; addr = 32'h203; wdata = 32'hAB;
    step();
    wr_en = 0; byte_op = 0; rd_en = 1; addr = 32'h200;
    settle();
    check("bc_stall", 32'(stall), 1);
    check("bc_rdata", rdata, 0);
    step(); settle();
    check("bc_drain_addr", maddr, 32'h203);
    check("bc_drain_byte", 32'(mbyte), 1);
    check("bc_drain_stall", 32'(stall), 1);
    ack = 1;
    step(); ack = 0; mrdata = 32'h12345678; settle();
    check("bc_read_we", 32'(we), 0);
    check("bc_read_addr", maddr, 32'h200);
    check("bc_read_stall", 32'(stall), 1);
    ack = 1; #1;
    check("bc_ack_stall", 32'(stall), 0);
    check("bc_ack_rdata", rdata, 32'h12345678);
    step(); rd_en = 0; ack = 0;

    // load during drain, then load-miss priority
    for (int k = 0; k < 3; k++) begin
      wr_en = 1; addr = 32'h400 + 32'(4 * k);
      wdata = 32'hB0 + 32'(k);
      step();
    end
    wr_en = 0; rd_en = 1; addr = 32'h300; ack = 1;
    settle();
    check("ld_dr_stall", 32'(stall), 1);
    check("ld_dr_addr", maddr, 32'h400);
    step(); ack = 0; mrdata = 32'hCAFEF00D; settle();
    check("ld_rd_addr", maddr, 32'h300);
    check("ld_rd_we", 32'(we), 0);
    ack = 1; #1;
    check("ld_rd_rdata", rdata, 32'hCAFEF00D);
    step(); rd_en = 0; ack = 0;
    rd_en = 1; addr = 32'h300; mrdata = 32'h5555AAAA;
    settle();
    check("pr_stall_c0", 32'(stall), 1);
    check("pr_req_c0", 32'(req), 0);
    for (int k = 1; k < 4; k++) begin
      step(); settle();
      check("pr_stall", 32'(stall), 1);
      check("pr_read", 32'(req & ~we), 1);
    end
    step(); ack = 1; settle();
    check("pr_ack_stall", 32'(stall), 0);
    check("pr_ack_rdata", rdata, 32'h5555AAAA);
    step(); rd_en = 0; settle();
    check("pr_idle", 32'(req), 0);
    step(); settle();
    check("pr_w0", maddr, 32'h404);
    step(); settle();
    check("pr_w1", maddr, 32'h408);
    step(); settle();
    check("pr_done", 32'(req), 0);
    ack = 0;

    // reset during READ with a store pending
    wr_en = 1; addr = 32'h600; wdata = 32'h66;
    step();
    wr_en = 0; rd_en = 1; addr = 32'h500;
    step(); settle();
    check("rr_read", 32'(req), 1);
    rd_en = 0; rst_n = 1'b0; #1;
    check("rr_async", 32'(req), 0);
    step(); rst_n = 1'b1;
    step(); settle();
    check("rr_idle1", 32'(req), 0);
    step(); settle();
    check("rr_idle2", 32'(req), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
